// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation: latch operands/opcode, hold EXEC (longer for mul/div), capture the 64-bit result, pulse done.
// Latency: done in cycle E2 (simple), E(2+MULDIV_WAIT) (mul/div), E1 (illegal); start is ignored while busy.
module alu_op_sequencer #(
   parameter int unsigned MULDIV_WAIT = 2
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  opcode,
   input  logic [31:0] ra_data,
   input  logic [31:0] rb_data,
   input  logic [63:0] alu_result,
   output logic [31:0] y_out,
   output logic [31:0] b_out,
   output logic [4:0]  alu_control,
   output logic [31:0] zhi,
   output logic [31:0] zlo,
   output logic        busy,
   output logic        done,
   output logic        illegal
);

   typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, DONE} state_t;

   localparam logic [3:0] WAIT_LIM = 4'(MULDIV_WAIT);

   state_t      state_q, state_d;
   logic [4:0]  op_q, op_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] y_q, y_d;
   logic [31:0] b_q, b_d;
   logic [31:0] zhi_q, zhi_d;
   logic [31:0] zlo_q, zlo_d;
   logic        ill_q, ill_d;

   function automatic logic is_legal(input logic [4:0] c);
      case (c)
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
         5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
         5'b10000, 5'b10001, 5'b10010, 5'b11111: is_legal = 1'b1;
         default:                                is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic is_muldiv(input logic [4:0] c);
      is_muldiv = (c == 5'b01111) || (c == 5'b10000);
   endfunction

   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q <= IDLE;
         op_q    <= 5'b00000;
         cnt_q   <= 4'd0;
         y_q     <= 32'd0;
         b_q     <= 32'd0;
         zhi_q   <= 32'd0;
         zlo_q   <= 32'd0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         b_q     <= b_d;
         zhi_q   <= zhi_d;
         zlo_q   <= zlo_d;
         ill_q   <= ill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      b_d     = b_q;
      zhi_d   = zhi_q;
      zlo_d   = zlo_q;
      ill_d   = ill_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (is_legal(opcode)) begin
                  y_d     = ra_data;
                  b_d     = rb_data;
                  op_d    = opcode;
                  ill_d   = 1'b0;
                  cnt_d   = 4'd0;
                  state_d = EXEC;
               end else begin
                  ill_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         EXEC: begin
            // The capture happens on the EXEC exit edge, so CAPTURE never holds a cycle.
            if (is_muldiv(op_q) && (cnt_q != WAIT_LIM)) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               zhi_d   = alu_result[63:32];
               zlo_d   = alu_result[31:0];
               state_d = DONE;
            end
         end
         CAPTURE: state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign y_out       = y_q;
   assign b_out       = b_q;
   assign alu_control = op_q;
   assign zhi         = zhi_q;
   assign zlo         = zlo_q;
   assign illegal     = ill_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random operations against a falling-edge ALU model and a per-operation expected-result model.
module tb_alu_op_sequencer;

   localparam int W = 2;

   logic        clock = 1'b0;
   logic        clear, start;
   logic [4:0]  opcode;
   logic [31:0] ra_data, rb_data;
   logic [63:0] alu_result;
   logic [31:0] y_out, b_out, zhi, zlo;
   logic [4:0]  alu_control;
   logic        busy, done, illegal;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_y, m_b, m_zhi, m_zlo;
   logic [4:0]  m_op;
   logic        m_ill;

   alu_op_sequencer #(.MULDIV_WAIT(W)) dut (
      .clock(clock), .clear(clear), .start(start), .opcode(opcode),
      .ra_data(ra_data), .rb_data(rb_data), .alu_result(alu_result),
      .y_out(y_out), .b_out(b_out), .alu_control(alu_control),
      .zhi(zhi), .zlo(zlo), .busy(busy), .done(done), .illegal(illegal)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] alu_fn(input logic [31:0] y, input logic [31:0] b, input logic [4:0] c);
      logic [31:0] r;
      r = 32'd0;
      case (c)
         5'b00011: r = y + b;
         5'b00100: r = y - b;
         5'b00101: r = y >> b[4:0];
         5'b00110: r = 32'($signed(y) >>> b[4:0]);
         5'b00111: r = y << b[4:0];
         5'b01000: r = (y >> b[4:0]) | (y << (6'd32 - {1'b0, b[4:0]}));
         5'b01001: r = (y << b[4:0]) | (y >> (6'd32 - {1'b0, b[4:0]}));
         5'b01010: r = y & b;
         5'b01011: r = y | b;
         5'b01111: return {32'd0, y} * {32'd0, b};
         5'b10000: return (b == 32'd0) ? 64'd0 : {y % b, y / b};
         5'b10001: r = -y;
         5'b10010: r = ~y;
         5'b11111: r = y + 32'd1;
         default:  r = 32'd0;
      endcase
      return {32'd0, r};
   endfunction

   // Behavioural ALU: registers its result on the falling edge.
   always @(negedge clock) alu_result <= alu_fn(y_out, b_out, alu_control);

   function automatic bit legal_ref(input logic [4:0] c);
      logic [4:0] tbl [14];
      tbl = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd31};
      foreach (tbl[i]) if (tbl[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".y"},   64'(y_out),       64'(m_y));
      check({tag, ".b"},   64'(b_out),       64'(m_b));
      check({tag, ".ctl"}, 64'(alu_control), 64'(m_op));
      check({tag, ".zhi"}, 64'(zhi),         64'(m_zhi));
      check({tag, ".zlo"}, 64'(zlo),         64'(m_zlo));
      check({tag, ".ill"}, 64'(illegal),     64'(m_ill));
   endtask

   // Called at #1 after a rising edge with the DUT idle; returns idle again.
   task automatic run_op(input string tag, input logic [31:0] ra, input logic [31:0] rb,
                         input logic [4:0] op, input bit inject);
      int  lat;
      bit  leg;
      leg = legal_ref(op);
      lat = !leg ? 1 : ((op == 5'b01111 || op == 5'b10000) ? 2 + W : 2);
      ra_data = ra; rb_data = rb; opcode = op; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      if (leg) begin
         m_y = ra; m_b = rb; m_op = op; m_ill = 1'b0;
         {m_zhi, m_zlo} = alu_fn(ra, rb, op);
      end else begin
         m_ill = 1'b1;
      end
      for (int k = 0; k <= lat; k++) begin
         check({tag, ".done"}, 64'(done), 64'(k == lat - 1));
         check({tag, ".busy"}, 64'(busy), 64'(k < lat));
         if (leg && k < lat) check({tag, ".ctl_hold"}, 64'(alu_control), 64'(op));
         if (inject && k == 0) begin
            start = 1'b1; ra_data = $urandom; rb_data = $urandom; opcode = 5'b00011;
         end
         if (k == 1) start = 1'b0;
         if (k < lat) begin @(posedge clock); #1; end
      end
      start = 1'b0;
      check_regs(tag);
   endtask

   task automatic model_reset();
      m_y = 0; m_b = 0; m_zhi = 0; m_zlo = 0; m_op = 0; m_ill = 0;
   endtask

   initial begin
      logic [4:0] legal_tbl [14];
      logic [4:0] op;
      legal_tbl = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd31};
      model_reset();
      clear = 1'b0; start = 1'b1; opcode = 5'b00011; ra_data = 32'd9; rb_data = 32'd9;
      @(posedge clock); @(posedge clock); #1;
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check_regs("rst");
      clear = 1'b1; start = 1'b0;
      @(posedge clock); #1;

      run_op("add", 32'd5, 32'd7, 5'b00011, 1'b0);
      check("add.zlo12", 64'(zlo), 64'd12);
      run_op("mul", 32'h0001_0000, 32'h0001_0000, 5'b01111, 1'b0);
      check("mul.zhi", 64'(zhi), 64'd1);
      run_op("add2", 32'd5, 32'd7, 5'b00011, 1'b0);
      run_op("illegal", 32'hdead, 32'hbeef, 5'b00000, 1'b0);
      check("illegal.zlo_kept", 64'(zlo), 64'd12);
      run_op("after_ill", 32'd100, 32'd1, 5'b00100, 1'b0);
      run_op("busy_ign", 32'd40, 32'd2, 5'b00011, 1'b1);
      run_op("busy_ign_div", 32'd1000, 32'd7, 5'b10000, 1'b1);
      run_op("neg_b", 32'd3, 32'h1234_5678, 5'b10001, 1'b0);

      // Clear in the middle of a mul EXEC.
      ra_data = 32'd3; rb_data = 32'd4; opcode = 5'b01111; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      check("midrst.busy_pre", 64'(busy), 64'd1);
      clear = 1'b0;
      @(posedge clock); #1;
      clear = 1'b1;
      model_reset();
      check("midrst.busy", 64'(busy), 64'd0);
      check("midrst.done", 64'(done), 64'd0);
      check_regs("midrst");
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         check("midrst.nodone", 64'(done), 64'd0);
      end
      run_op("post_rst_add", 32'd20, 32'd22, 5'b00011, 1'b0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) < 7) op = legal_tbl[$urandom_range(0, 13)];
         else op = 5'($urandom_range(0, 31));
         run_op("rand", $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                op, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: MULDIV_WAIT, default 2, extra EXEC cycles held for mul/div codes (legal range 0..15).
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 opcode  input  5  ALU control code for the requested operation.
REQ-006 ra_data  input  32  first operand; captured into the Y register.
REQ-007 rb_data  input  32  second operand; captured into the B operand register.
REQ-008 alu_result  input  64  ALU result; the ALU registers it on the falling clock edge.
REQ-009 y_out  output  32  Y operand to the ALU.
REQ-010 b_out  output  32  B operand to the ALU.
REQ-011 alu_control  output  5  operation code to the ALU.
REQ-012 zhi  output  32  captured alu_result[63:32].
REQ-013 zlo  output  32  captured alu_result[31:0].
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 illegal  output  1  last accepted opcode was not a legal code; held until next accept.

Function
REQ-017 Legal codes SHALL be: 00011 add, 00100 sub, 00101 shr, 00110 sra, 00111 shl, 01000 ror, 01001 rol, 01010 and, 01011 or, 01111 mul, 10000 div, 10001 neg, 10010 not, 11111 inc; all others are illegal.
REQ-018 States SHALL be IDLE, EXEC, CAPTURE, DONE.
REQ-019 IDLE with start=1 at edge E0 SHALL load y_out<=ra_data, b_out<=rb_data, op register<=opcode, clear illegal, and go to EXEC; for an illegal code it SHALL set illegal=1 and go directly to DONE, leaving Y, B, op register, zhi and zlo unchanged.
REQ-020 alu_control SHALL equal the op register at all times, stable for the whole EXEC/CAPTURE interval.
REQ-021 EXEC SHALL last 1 cycle for non-mul/div codes and 1+MULDIV_WAIT cycles for 01111/10000, using a 4-bit wait counter cleared on entry.
REQ-022 CAPTURE SHALL, on its entry edge, not yet sample; at the exit edge of EXEC zhi<=alu_result[63:32] and zlo<=alu_result[31:0], then CAPTURE lasts 0 cycles: the FSM goes EXEC->DONE on that edge (CAPTURE is the capture action, encoded as the EXEC-exit transition).
REQ-023 DONE SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge.
REQ-024 Latency SHALL be: done high in cycle E2 for simple ops, E(2+MULDIV_WAIT) for mul/div, E1 for illegal codes.
REQ-025 start while busy=1 (EXEC or DONE) SHALL be ignored with no effect on any register.
REQ-026 Codes 10001, 10010, 11111 use Y only; b_out SHALL still be loaded from rb_data.
REQ-027 zhi/zlo SHALL hold their values between operations; no width conversion beyond the 64-bit split.

Reset
REQ-028 clear=0 at a rising edge SHALL force IDLE, op register=00000, counter=0, y_out=b_out=zhi=zlo=0, busy=done=illegal=0, from any state including mid-EXEC.
REQ-029 start asserted in the same cycle as clear=0 SHALL be ignored.

Verification (bench uses a behavioural negedge-registered ALU model)
REQ-030 add: ra=5, rb=7, opcode=00011, start at E0 -> alu_control=00011, zlo=12, zhi=0, done=1 only in cycle E2.
REQ-031 mul, MULDIV_WAIT=2: ra=0x00010000, rb=0x00010000, opcode=01111 -> zhi=0x00000001, zlo=0x00000000, done only in cycle E4.
REQ-032 illegal: prior zlo=12, opcode=00000 -> illegal=1, done in E1, zlo stays 12; next legal accept clears illegal.
REQ-033 start pulsed in EXEC with different operands -> ignored; result matches first request only.
REQ-034 clear=0 during mul EXEC -> next cycle IDLE, all outputs 0, no done pulse; fresh add afterwards completes normally.
